// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch channel: request/address out, ready/data back.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register, branch flush, freeze skid buffer and
// drain of an outstanding fetch when a branch arrives mid-transfer.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                branch_taken,
  input  logic [31:0]         branch_addr,
  fetch_stage_if.master       imem,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_instr,
  output logic                if_valid
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic [31:0] buf_instr_q;
  logic [31:0] buf_pc_q;
  logic [31:0] br_tgt;
  logic [31:0] pc_inc;

  assign br_tgt = {branch_addr[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  // pc_q is only advanced once a transfer completes, so it doubles as the stable address.
  assign imem.imem_req  = (state_q == StFetch) || (state_q == StDrain);
  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      tgt_q       <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      if_pc       <= 32'h0;
      if_instr    <= NOP_INSTR;
      if_valid    <= 1'b0;
    end else begin
      // IF/ID default: flush beats freeze-hold beats bubble; loads below override.
      if (branch_taken) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
        if_pc    <= 32'h0;
      end else if (!freeze) begin
        if_valid <= 1'b0;
        if_instr <= NOP_INSTR;
      end

      case (state_q)
        StIdle: state_q <= StFetch;

        StFetch: begin
          if (imem.imem_ready) begin
            if (branch_taken) begin
              pc_q <= br_tgt;
            end else if (freeze) begin
              buf_instr_q <= imem.imem_rdata;
              buf_pc_q    <= pc_inc;
              pc_q        <= pc_inc;
              state_q     <= StHold;
            end else begin
              if_pc    <= pc_inc;
              if_instr <= imem.imem_rdata;
              if_valid <= 1'b1;
              pc_q     <= pc_inc;
            end
          end else if (branch_taken) begin
            tgt_q   <= br_tgt;
            state_q <= StDrain;
          end
        end

        StHold: begin
          if (branch_taken) begin
            pc_q    <= br_tgt;
            state_q <= StFetch;
          end else if (!freeze) begin
            if_pc    <= buf_pc_q;
            if_instr <= buf_instr_q;
            if_valid <= 1'b1;
            state_q  <= StFetch;
          end
        end

        StDrain: begin
          // Returning data belongs to the squashed path and is dropped.
          if (imem.imem_ready) begin
            pc_q    <= branch_taken ? br_tgt : tgt_q;
            state_q <= StFetch;
          end else if (branch_taken) begin
            tgt_q <= br_tgt;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: expected IF/ID loads are queued by the stimulus and
// checked by an independent monitor; memory returns word = address.
module tb_fetch_stage;
  localparam logic [31:0] Nop = 32'hE1A0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  logic        frz_at_edge = 1'b0;

  fetch_stage_if mem ();

  assign mem.imem_ready = ready;
  assign mem.imem_rdata = ready ? mem.imem_addr : 32'hBAD0_BAD0;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(Nop)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem        (mem),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int k = 0;
    while (!(mem.imem_req && mem.imem_addr == a) && k < 64) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k >= 64) begin
      n_fail++;
      $display("FAIL wait_addr: got %h, expected request at %h", mem.imem_addr, a);
    end
  endtask

  // A valid IF/ID after an edge without freeze is a fresh load.
  always @(posedge clk) frz_at_edge <= freeze;

  always @(negedge clk) begin
    if (rst && if_valid && !frz_at_edge) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL ifid_load: got pc=%h instr=%h, expected no load", if_pc, if_instr);
      end else begin
        exp_e = exp_q.pop_front();
        if ({if_pc, if_instr} !== exp_e) begin
          n_fail++;
          $display("FAIL ifid_load: got pc=%h instr=%h, expected pc=%h instr=%h",
                   if_pc, if_instr, exp_e[63:32], exp_e[31:0]);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(if_valid), 32'h0);
    chk("rst_instr", if_instr, Nop);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_req", 32'(mem.imem_req), 32'h0);
    chk("rst_addr", mem.imem_addr, 32'h0);

    for (int i = 0; i < 4; i++) push(32'(4 * i + 4), 32'(4 * i));
    rst = 1'b1;
    @(negedge clk);
    chk("first_req", 32'(mem.imem_req), 32'h1);
    chk("first_addr", mem.imem_addr, 32'h0);
    chk("first_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    chk("second_valid", 32'(if_valid), 32'h1);
    chk("second_pc", if_pc, 32'h4);

    // Three wait cycles on the fetch at 0x10.
    wait_addr(32'h10);
    push(32'h14, 32'h10);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_addr", mem.imem_addr, 32'h10);
      chk("stall_req", 32'(mem.imem_req), 32'h1);
      chk("stall_bubble", 32'(if_valid), 32'h0);
    end
    ready = 1'b1;

    // Freeze for two cycles while the fetch at 0x20 completes.
    push(32'h18, 32'h14);
    push(32'h1C, 32'h18);
    push(32'h20, 32'h1C);
    wait_addr(32'h20);
    freeze = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_pc", if_pc, 32'h20);
      chk("hold_valid", 32'(if_valid), 32'h1);
      chk("hold_req", 32'(mem.imem_req), 32'h0);
    end
    push(32'h24, 32'h20);
    freeze = 1'b0;
    @(negedge clk);
    chk("resume_pc", if_pc, 32'h24);
    chk("resume_req", 32'(mem.imem_req), 32'h1);
    chk("resume_addr", mem.imem_addr, 32'h24);

    // Taken branch during a zero-wait fetch at 0x30.
    push(32'h28, 32'h24);
    push(32'h2C, 32'h28);
    push(32'h30, 32'h2C);
    wait_addr(32'h30);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    @(negedge clk);
    chk("flush_valid", 32'(if_valid), 32'h0);
    chk("flush_instr", if_instr, Nop);
    chk("flush_pc", if_pc, 32'h0);
    chk("br_addr", mem.imem_addr, 32'h100);
    chk("br_req", 32'(mem.imem_req), 32'h1);
    push(32'h104, 32'h100);
    branch_taken = 1'b0;
    @(negedge clk);

    // Branch together with freeze: flush must win over hold.
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    freeze       = 1'b1;
    @(negedge clk);
    chk("brfrz_valid", 32'(if_valid), 32'h0);
    chk("brfrz_instr", if_instr, Nop);
    chk("brfrz_pc", if_pc, 32'h0);
    chk("brfrz_addr", mem.imem_addr, 32'h40);

    // Stalled fetch at 0x40, then two branches while it is outstanding.
    branch_taken = 1'b0;
    freeze       = 1'b0;
    ready        = 1'b0;
    @(negedge clk);
    chk("st40_addr", mem.imem_addr, 32'h40);
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    @(negedge clk);
    chk("drain_addr", mem.imem_addr, 32'h40);
    chk("drain_req", 32'(mem.imem_req), 32'h1);
    branch_addr = 32'h302;
    @(negedge clk);
    chk("drain2_addr", mem.imem_addr, 32'h40);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("drain3_addr", mem.imem_addr, 32'h40);
    chk("drain3_valid", 32'(if_valid), 32'h0);
    push(32'h304, 32'h300);
    ready = 1'b1;
    @(negedge clk);
    chk("tgt_addr", mem.imem_addr, 32'h300);
    chk("tgt_req", 32'(mem.imem_req), 32'h1);
    chk("tgt_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    freeze = 1'b1;
    repeat (3) @(negedge clk);
    chk("end_pc", if_pc, 32'h304);
    chk("end_req", 32'(mem.imem_req), 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the ARM core, directly upstream of the decode stage and the hazard detection unit. It owns the PC, issues fetches to instruction memory over a req/ready handshake, and applies `freeze` from the hazard unit to PC and IF/ID. It flushes on `branch_taken` from EXE and buffers an instruction that returns while the pipeline is frozen.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0000: instruction word loaded into IF/ID on flush or bubble.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `freeze` input 1: hazard_detected from the hazard unit; holds PC and IF/ID.
- `branch_taken` input 1: branch resolved taken in EXE.
- `branch_addr` input 32: branch target.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address, word-aligned.
- `imem_ready` input 1: memory has data for the current request this cycle.
- `imem_rdata` input 32: instruction word, valid when `imem_ready`=1.
- `if_pc` output 32: IF/ID register: fetch address + 4.
- `if_instr` output 32: IF/ID register: instruction.
- `if_valid` output 1: IF/ID register holds a real instruction.

## Operation
- Registers:
  - `pc`.
  - `tgt` (pending branch target).
  - `buf_instr` / `buf_pc` (skid buffer).
  - FSM state: IDLE, FETCH, HOLD, DRAIN.
  - IF/ID.
- Handshake: while `imem_req`=1 and `imem_ready`=0, `imem_addr` must not change. A transfer completes on the edge where `imem_req`&`imem_ready`=1.
- `imem_req`=1 in FETCH and DRAIN only.
  - FETCH: `imem_addr`=`pc`.
  - DRAIN: `imem_addr`=`pc`, the old, outstanding address.
- IDLE: entered on reset. Goes to FETCH on the next edge, with no request.
- FETCH, `imem_ready`=1:
  - With `branch_taken`: discard data; `pc`<=`branch_addr`; stay in FETCH.
  - Else with `freeze`: `buf_instr`<=`imem_rdata`; `buf_pc`<=`pc`+4; `pc`<=`pc`+4; go to HOLD.
  - Else: IF/ID<=(`pc`+4, `imem_rdata`, valid=1); `pc`<=`pc`+4.
- FETCH, `imem_ready`=0:
  - With `branch_taken`: `tgt`<=`branch_addr`; go to DRAIN.
  - Else stay in FETCH.
- HOLD (no request):
  - With `branch_taken`: drop buffer; `pc`<=`branch_addr`; go to FETCH.
  - Else with `freeze`: stay in HOLD.
  - Else: IF/ID<=buffer with valid=1; go to FETCH.
- DRAIN, `imem_ready`=1: discard data. `pc`<=`branch_addr` if `branch_taken` is also asserted, else `tgt`. Go to FETCH.
- DRAIN, `imem_ready`=0, with `branch_taken`: `tgt`<=`branch_addr`.
- IF/ID priority, highest first:
  1. `branch_taken`: `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=0. This applies even when `freeze`=1.
  2. `freeze`: hold.
  3. Load, per the rules above.
  4. Otherwise bubble: `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc` unchanged.
- PC arithmetic: 32-bit, `pc`+4 wraps modulo 2^32. `branch_addr`[1:0] is ignored; `pc`[1:0] is always 0.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state=IDLE, `pc`=`RESET_PC`, `tgt`=0, buffer=0.
  - `if_valid`=0, `if_instr`=`NOP_INSTR`, `if_pc`=0.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
- Reset mid-transfer abandons the request. Memory is required to tolerate `imem_req` dropping.
- First request is asserted in the first cycle after the first edge with `rst`=1.
- With zero-wait memory (`imem_ready` tied 1), throughput is one instruction per cycle. IF/ID loads on the same edge that completes the transfer.
- With N wait cycles, N bubbles enter IF/ID per fetch.
- Branch penalty:
  - Target request is issued the cycle after `branch_taken` when no fetch is outstanding.
  - Otherwise it is issued the cycle after the outstanding fetch completes.
- Freeze is applied on the same edge it is sampled. After release, a buffered instruction reaches IF/ID on the next edge, and the request resumes in the cycle after that.

## Test plan
- Reset, zero-wait memory returning word=addr: `if_pc` sequence 4, 8, C, …; `if_valid`=1 from the second edge after reset release.
- `imem_ready` low 3 cycles at addr 0x10: `imem_addr` stable at 0x10 throughout; 3 bubbles; then `if_pc`=0x14.
- `freeze` high 2 cycles while `imem_ready`=1 at addr 0x20: IF/ID holds its prior value; next request is not issued during HOLD; after release `if_pc`=0x24, then a fetch at 0x24.
- `branch_taken`, `branch_addr`=0x100 during a zero-wait fetch at 0x30: next edge `if_valid`=0; next `imem_addr`=0x100; data for 0x30 never appears in IF/ID.
- `branch_taken`(0x200) while the fetch at 0x40 is stalled, then `branch_taken`(0x300) one cycle later: `imem_addr` stays 0x40 until ready; the next request is 0x300.
- `branch_taken` and `freeze` asserted together: IF/ID is flushed (`if_valid`=0), not held.
